// File: rtl/i2f_arbiter.sv
// Round-robin arbiter that time-shares one fixed-point to bfloat16 converter.
// One conversion is in flight at a time; a watchdog turns a silent converter into an error response.
module i2f_arbiter #(
    parameter int N_REQ     = 4,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 7,
    parameter int TIMEOUT   = 64,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*EXP_WIDTH-1:0] int_i,
    input  logic [N_REQ*MAN_WIDTH-1:0] frac_i,
    output logic [N_REQ-1:0]           done_o,
    output logic [ID_W-1:0]            res_id_o,
    output logic                       res_sgn_o,
    output logic [EXP_WIDTH-1:0]       res_exp_o,
    output logic [MAN_WIDTH-1:0]       res_man_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic                       cvt_valid_o,
    output logic [EXP_WIDTH-1:0]       cvt_int_o,
    output logic [MAN_WIDTH-1:0]       cvt_frac_o,
    input  logic                       cvt_valid_i,
    input  logic                       cvt_sgn_i,
    input  logic [EXP_WIDTH-1:0]       cvt_exp_i,
    input  logic [MAN_WIDTH-1:0]       cvt_man_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state_q,    state_d;
    logic [ID_W-1:0]      ptr_q,      ptr_d;
    logic [ID_W-1:0]      id_q,       id_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [EXP_WIDTH-1:0] cvt_int_q,  cvt_int_d;
    logic [MAN_WIDTH-1:0] cvt_frac_q, cvt_frac_d;
    logic                 cvt_vld_q,  cvt_vld_d;
    logic [N_REQ-1:0]     done_q,     done_d;
    logic [ID_W-1:0]      res_id_q,   res_id_d;
    logic                 res_sgn_q,  res_sgn_d;
    logic [EXP_WIDTH-1:0] res_exp_q,  res_exp_d;
    logic [MAN_WIDTH-1:0] res_man_q,  res_man_d;
    logic                 err_q,      err_d;

    logic                 grant_vld;
    logic [ID_W-1:0]      grant_id;
    logic [EXP_WIDTH-1:0] grant_int;
    logic [MAN_WIDTH-1:0] grant_frac;

    // First requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin : arb
        int idx;
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_int  = '0;
        grant_frac = '0;
        idx        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!grant_vld && req_i[idx]) begin
                grant_vld  = 1'b1;
                grant_id   = ID_W'(idx);
                grant_int  = int_i[idx*EXP_WIDTH +: EXP_WIDTH];
                grant_frac = frac_i[idx*MAN_WIDTH +: MAN_WIDTH];
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path through the case statement can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        cvt_int_d  = cvt_int_q;
        cvt_frac_d = cvt_frac_q;
        cvt_vld_d  = 1'b0;
        done_d     = '0;
        res_id_d   = res_id_q;
        res_sgn_d  = res_sgn_q;
        res_exp_d  = res_exp_q;
        res_man_d  = res_man_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    id_d       = grant_id;
                    cvt_int_d  = grant_int;
                    cvt_frac_d = grant_frac;
                    cvt_vld_d  = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A converter answer in the expiry cycle still counts as a success.
                if (cvt_valid_i) begin
                    res_sgn_d    = cvt_sgn_i;
                    res_exp_d    = cvt_exp_i;
                    res_man_d    = cvt_man_i;
                    err_d        = 1'b0;
                    res_id_d     = id_q;
                    done_d[id_q] = 1'b1;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_sgn_d    = 1'b0;
                    res_exp_d    = '0;
                    res_man_d    = '0;
                    err_d        = 1'b1;
                    res_id_d     = id_q;
                    done_d[id_q] = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            cvt_int_q  <= '0;
            cvt_frac_q <= '0;
            cvt_vld_q  <= 1'b0;
            done_q     <= '0;
            res_id_q   <= '0;
            res_sgn_q  <= 1'b0;
            res_exp_q  <= '0;
            res_man_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            cvt_int_q  <= cvt_int_d;
            cvt_frac_q <= cvt_frac_d;
            cvt_vld_q  <= cvt_vld_d;
            done_q     <= done_d;
            res_id_q   <= res_id_d;
            res_sgn_q  <= res_sgn_d;
            res_exp_q  <= res_exp_d;
            res_man_q  <= res_man_d;
            err_q      <= err_d;
        end
    end

    assign done_o      = done_q;
    assign res_id_o    = res_id_q;
    assign res_sgn_o   = res_sgn_q;
    assign res_exp_o   = res_exp_q;
    assign res_man_o   = res_man_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != S_IDLE);
    assign cvt_valid_o = cvt_vld_q;
    assign cvt_int_o   = cvt_int_q;
    assign cvt_frac_o  = cvt_frac_q;

endmodule

// File: tb/tb_i2f_arbiter.sv
// Scoreboard bench for i2f_arbiter: directed requests push hand-computed responses,
// a converter model answers with configurable latency, and a monitor checks every done pulse.
module tb_i2f_arbiter;

    localparam int N_REQ     = 4;
    localparam int EXP_WIDTH = 8;
    localparam int MAN_WIDTH = 7;
    localparam int TIMEOUT   = 64;
    localparam int ID_W      = 2;

    logic                       clk;
    logic                       rst;
    logic [N_REQ-1:0]           req_i;
    logic [N_REQ*EXP_WIDTH-1:0] int_i;
    logic [N_REQ*MAN_WIDTH-1:0] frac_i;
    logic [N_REQ-1:0]           done_o;
    logic [ID_W-1:0]            res_id_o;
    logic                       res_sgn_o;
    logic [EXP_WIDTH-1:0]       res_exp_o;
    logic [MAN_WIDTH-1:0]       res_man_o;
    logic                       err_o;
    logic                       busy_o;
    logic                       cvt_valid_o;
    logic [EXP_WIDTH-1:0]       cvt_int_o;
    logic [MAN_WIDTH-1:0]       cvt_frac_o;
    logic                       cvt_valid_i;
    logic                       cvt_sgn_i;
    logic [EXP_WIDTH-1:0]       cvt_exp_i;
    logic [MAN_WIDTH-1:0]       cvt_man_i;

    i2f_arbiter #(
        .N_REQ(N_REQ), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .int_i(int_i), .frac_i(frac_i),
        .done_o(done_o), .res_id_o(res_id_o), .res_sgn_o(res_sgn_o), .res_exp_o(res_exp_o),
        .res_man_o(res_man_o), .err_o(err_o), .busy_o(busy_o), .cvt_valid_o(cvt_valid_o),
        .cvt_int_o(cvt_int_o), .cvt_frac_o(cvt_frac_o), .cvt_valid_i(cvt_valid_i),
        .cvt_sgn_i(cvt_sgn_i), .cvt_exp_i(cvt_exp_i), .cvt_man_i(cvt_man_i)
    );

    typedef struct {
        logic [ID_W-1:0]      id;
        logic                 sgn;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH-1:0] man;
        logic                 err;
        int                   lat;
    } resp_t;

    resp_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    issue_cyc = 0;
    int    lat_cfg = 3;
    bit    silent = 1'b0;
    int    late_req = 0;
    int    late_ack = 0;
    int    cd = 0;
    logic  prev_cv = 1'b0;
    logic                 m_sgn;
    logic [EXP_WIDTH-1:0] m_exp;
    logic [MAN_WIDTH-1:0] m_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sign-magnitude fixed point {int[6:0].frac} normalised to bfloat16 fields.
    task automatic convert(input logic [7:0] iv, input logic [6:0] fv,
                           output logic s, output logic [7:0] e, output logic [6:0] m);
        logic [13:0] v;
        int p;
        s = iv[7];
        v = {iv[6:0], fv};
        p = -1;
        for (int b = 0; b < 14; b++) if (v[b]) p = b;
        if (p < 0) begin
            e = '0;
            m = '0;
        end else begin
            e = 8'(120 + p);
            v = v << (13 - p);
            m = v[12:6];
        end
    endtask

    // Converter model: answers lat_cfg cycles after the start pulse unless silent.
    initial begin
        cvt_valid_i = 1'b0; cvt_sgn_i = 1'b0; cvt_exp_i = '0; cvt_man_i = '0;
        forever begin
            tick();
            cvt_valid_i = 1'b0; cvt_sgn_i = 1'b0; cvt_exp_i = '0; cvt_man_i = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !silent) begin
                    cvt_valid_i = 1'b1; cvt_sgn_i = m_sgn; cvt_exp_i = m_exp; cvt_man_i = m_man;
                end
            end else if (late_req != late_ack) begin
                late_ack++;
                cvt_valid_i = 1'b1; cvt_sgn_i = 1'b1; cvt_exp_i = 8'hAA; cvt_man_i = 7'h55;
            end
            if (cvt_valid_o) begin
                cd        = lat_cfg;
                issue_cyc = cyc;
                convert(cvt_int_o, cvt_frac_o, m_sgn, m_exp, m_man);
            end
        end
    end

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        resp_t e;
        logic [N_REQ-1:0] onehot;
        forever begin
            @(negedge clk);
            if (cvt_valid_o) begin
                check("cvt_valid_single", 32'(prev_cv), 32'd0);
                check("busy_at_issue", 32'(busy_o), 32'd1);
            end
            prev_cv = cvt_valid_o;
            if (done_o != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    onehot = '0;
                    onehot[e.id] = 1'b1;
                    check("done_onehot", 32'(done_o), 32'(onehot));
                    check("res_id", 32'(res_id_o), 32'(e.id));
                    check("res_sgn", 32'(res_sgn_o), 32'(e.sgn));
                    check("res_exp", 32'(res_exp_o), 32'(e.exp));
                    check("res_man", 32'(res_man_o), 32'(e.man));
                    check("err", 32'(err_o), 32'(e.err));
                    check("latency", 32'(cyc - issue_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic set_op(input int k, input logic [7:0] iv, input logic [6:0] fv);
        int_i[k*EXP_WIDTH +: EXP_WIDTH]  = iv;
        frac_i[k*MAN_WIDTH +: MAN_WIDTH] = fv;
    endtask

    task automatic expect_resp(input logic [ID_W-1:0] id, input logic s, input logic [7:0] e,
                               input logic [6:0] m, input logic err, input int lat);
        resp_t r;
        r.id = id; r.sgn = s; r.exp = e; r.man = m; r.err = err; r.lat = lat;
        sb_q.push_back(r);
    endtask

    task automatic wait_done(input int n, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            tick();
            if (done_o != '0) seen++;
        end
        check("done_count", 32'(seen), 32'(n));
    endtask

    initial begin
        rst = 1'b1; req_i = '0; int_i = '0; frac_i = '0;
        repeat (3) tick();
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cvt_valid", 32'(cvt_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_res_id", 32'(res_id_o), 32'd0);
        check("rst_res", 32'({res_sgn_o, res_exp_o, res_man_o}), 32'd0);
        check("rst_cvt_ops", 32'({cvt_int_o, cvt_frac_o}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic single request, L=3.
        set_op(0, 8'h01, 7'h5F);
        expect_resp(2'd0, 1'b0, 8'h7F, 7'h5F, 1'b0, 4);
        req_i = 4'b0001;
        wait_done(1, 50);
        req_i = '0;

        set_op(2, 8'h00, 7'h01);
        expect_resp(2'd2, 1'b0, 8'h78, 7'h00, 1'b0, 4);
        req_i = 4'b0100;
        wait_done(1, 50);
        req_i = '0;

        // Negative operand; request and operands withdrawn after the grant.
        set_op(3, 8'h83, 7'h00);
        expect_resp(2'd3, 1'b1, 8'h80, 7'h40, 1'b0, 4);
        req_i = 4'b1000;
        tick();
        tick();
        req_i = '0;
        set_op(3, 8'h11, 7'h22);
        wait_done(1, 50);

        // All four requesting continuously, pointer starts at 0.
        set_op(0, 8'h01, 7'h00);
        set_op(1, 8'h02, 7'h40);
        set_op(2, 8'h03, 7'h00);
        set_op(3, 8'h04, 7'h10);
        expect_resp(2'd0, 1'b0, 8'h7F, 7'h00, 1'b0, 4);
        expect_resp(2'd1, 1'b0, 8'h80, 7'h20, 1'b0, 4);
        expect_resp(2'd2, 1'b0, 8'h80, 7'h40, 1'b0, 4);
        expect_resp(2'd3, 1'b0, 8'h81, 7'h04, 1'b0, 4);
        expect_resp(2'd0, 1'b0, 8'h7F, 7'h00, 1'b0, 4);
        req_i = 4'b1111;
        wait_done(5, 200);
        req_i = '0;

        // Silent converter: watchdog error after TIMEOUT cycles in WAIT.
        silent = 1'b1;
        set_op(1, 8'h05, 7'h00);
        expect_resp(2'd1, 1'b0, 8'h00, 7'h00, 1'b1, TIMEOUT + 1);
        req_i = 4'b0010;
        wait_done(1, 150);
        req_i = '0;
        repeat (3) tick();
        check("err_hold", 32'(err_o), 32'd1);
        check("res_hold", 32'({res_exp_o, res_man_o}), 32'd0);
        check("busy_idle", 32'(busy_o), 32'd0);
        silent = 1'b0;
        late_req++;
        repeat (4) tick();
        check("late_resp_busy", 32'(busy_o), 32'd0);
        check("late_resp_err", 32'(err_o), 32'd1);
        check("late_resp_exp", 32'(res_exp_o), 32'd0);

        set_op(0, 8'h05, 7'h00);
        expect_resp(2'd0, 1'b0, 8'h81, 7'h20, 1'b0, 4);
        req_i = 4'b0001;
        wait_done(1, 50);
        req_i = '0;

        // Converter answers in the very cycle the watchdog would fire.
        lat_cfg = TIMEOUT;
        set_op(2, 8'h01, 7'h5F);
        expect_resp(2'd2, 1'b0, 8'h7F, 7'h5F, 1'b0, TIMEOUT + 1);
        req_i = 4'b0100;
        wait_done(1, 150);
        req_i = '0;
        lat_cfg = 3;

        // Asynchronous reset while waiting; no done for the aborted request.
        silent = 1'b1;
        set_op(1, 8'h05, 7'h00);
        req_i = 4'b0010;
        repeat (6) tick();
        check("wait_busy", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_res", 32'({res_sgn_o, res_exp_o, res_man_o}), 32'd0);
        check("async_res_id", 32'(res_id_o), 32'd0);
        check("async_cvt_ops", 32'({cvt_int_o, cvt_frac_o}), 32'd0);
        req_i = '0;
        tick();
        rst = 1'b0;
        silent = 1'b0;
        set_op(3, 8'h83, 7'h00);
        expect_resp(2'd1, 1'b0, 8'h81, 7'h20, 1'b0, 4);
        req_i = 4'b1010;
        wait_done(1, 50);
        req_i = '0;

        repeat (4) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
